layer_serializer: RTL and testbench

- Consumes the parallel output bus of one neuron layer: NEURON_NUM words, each with its own valid bit.
- Gathers one complete frame (one word from every neuron) into a holding register.
- Streams the frame out one word per clock, lowest neuron first, as the serial input stream the next layer's neurons consume.
- Sits between consecutive layer instances in the network top. It is the reader side of the layer's parallel output interface.

---
 rtl/layer_serializer.sv | 96 +++++++++
 tb/tb_layer_serializer.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/layer_serializer.sv
// layer_serializer: gathers one word per neuron into a frame, then streams it out
// one word per clock, lowest neuron first, for the next layer.
module layer_serializer #(
  parameter int NEURON_NUM = 30,
  parameter int DATA_WIDTH = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NEURON_NUM*DATA_WIDTH-1:0] layer_data_in,
  input  logic [NEURON_NUM-1:0]          layer_valid_in,
  output logic [DATA_WIDTH-1:0]          next_input,
  output logic                           next_input_valid,
  output logic                           busy,
  output logic                           frame_done,
  output logic                           overrun
);
  localparam int W  = NEURON_NUM * DATA_WIDTH;
  localparam int CW = $clog2(NEURON_NUM + 1);
  typedef enum logic {IDLE, STREAM} state_t;
  state_t                  state_q, state_d;
  logic [W-1:0]            hold_q, hold_d, shift_q, shift_d;
  logic [NEURON_NUM-1:0]   flag_q, flag_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   next_input_q, next_input_d;
  logic                    valid_q, valid_d, busy_q, busy_d;
  logic                    frame_done_q, frame_done_d, overrun_q, overrun_d;
  logic                    all_flags, last, load;
  assign all_flags        = &flag_q;
  assign next_input       = next_input_q;
  assign next_input_valid = valid_q;
  assign busy             = busy_q;
  assign frame_done       = frame_done_q;
  assign overrun          = overrun_q;
  always_comb begin
    last         = state_q == STREAM && cnt_q == CW'(NEURON_NUM);
    load         = all_flags && (state_q == IDLE || last);
    state_d      = state_q;
    shift_d      = shift_q;
    cnt_d        = cnt_q;
    next_input_d = next_input_q;
    valid_d      = valid_q;
    busy_d       = busy_q;
    frame_done_d = last;
    hold_d       = hold_q;
    overrun_d    = overrun_q;
    if (load) begin
      next_input_d = hold_q[DATA_WIDTH-1:0];
      valid_d      = 1'b1;
      busy_d       = 1'b1;
      shift_d      = hold_q >> DATA_WIDTH;
      cnt_d        = CW'(1);
      state_d      = STREAM;
    end else if (state_q == STREAM && !last) begin
      next_input_d = shift_q[DATA_WIDTH-1:0];
      valid_d      = 1'b1;
      shift_d      = shift_q >> DATA_WIDTH;
      cnt_d        = cnt_q + CW'(1);
    end else begin
      valid_d = 1'b0;
      busy_d  = 1'b0;
      state_d = IDLE;
    end
    // A capture coinciding with a LOAD belongs to the next frame, so the clear does not block it.
    for (int i = 0; i < NEURON_NUM; i++)
      if (layer_valid_in[i]) begin
        if (flag_q[i] && !load) overrun_d = 1'b1;
        else hold_d[i*DATA_WIDTH +: DATA_WIDTH] = layer_data_in[i*DATA_WIDTH +: DATA_WIDTH];
      end
    flag_d = (load ? '0 : flag_q) | layer_valid_in;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      hold_q       <= '0;
      shift_q      <= '0;
      flag_q       <= '0;
      cnt_q        <= '0;
      next_input_q <= '0;
      valid_q      <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      shift_q      <= shift_d;
      flag_q       <= flag_d;
      cnt_q        <= cnt_d;
      next_input_q <= next_input_d;
      valid_q      <= valid_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      overrun_q    <= overrun_d;
    end
  end
endmodule

// File: tb/tb_layer_serializer.sv
// tb_layer_serializer: randomized and directed frames against a frame-level reference
// model; expected words are queued with the edge they must appear after.
module tb_layer_serializer;
  localparam int N  = 10;
  localparam int DW = 16;
  logic              clk = 1'b0;
  logic              rst_n;
  logic [N*DW-1:0]   din;
  logic [N-1:0]      vin;
  logic [DW-1:0]     next_input;
  logic              next_input_valid, busy, frame_done, overrun;
  layer_serializer #(.NEURON_NUM(N), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n), .layer_data_in(din), .layer_valid_in(vin),
    .next_input(next_input), .next_input_valid(next_input_valid),
    .busy(busy), .frame_done(frame_done), .overrun(overrun)
  );
  always #5 clk = ~clk;
  typedef struct {int e; logic [DW-1:0] w;} exp_t;
  exp_t          wq[$];
  int            fdq[$];
  int            n_cmp = 0, n_bad = 0, cyc = 0, nfree = 0;
  logic [DW-1:0] mhold [N];
  logic [N-1:0]  mflag = '0;
  logic          movr = 1'b0, mon_en = 1'b0;
  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endfunction
  // Reference model: a frame is taken once every neuron has delivered and the
  // output is free; its words then appear on N consecutive cycles.
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      wq.delete();
      fdq.delete();
      mflag = '0;
      movr = 1'b0;
      nfree = 0;
      foreach (mhold[i]) mhold[i] = '0;
    end else begin
      automatic logic ld;
      cyc++;
      ld = (&mflag) && cyc >= nfree;
      if (ld) begin
        for (int k = 0; k < N; k++) wq.push_back('{cyc + k, mhold[k]});
        fdq.push_back(cyc + N);
        nfree = cyc + N;
      end
      for (int i = 0; i < N; i++)
        if (vin[i]) begin
          if (mflag[i] && !ld) movr = 1'b1;
          else mhold[i] = din[i*DW +: DW];
        end
      mflag = (ld ? '0 : mflag) | vin;
    end
  end
  initial forever begin
    @(negedge clk);
    if (mon_en) begin
      automatic logic ev  = wq.size() > 0 && wq[0].e == cyc;
      automatic logic efd = fdq.size() > 0 && fdq[0] == cyc;
      chk("valid", 32'(next_input_valid), 32'(ev));
      chk("busy", 32'(busy), 32'(ev));
      chk("frame_done", 32'(frame_done), 32'(efd));
      chk("overrun", 32'(overrun), 32'(movr));
      if (ev) begin
        if (next_input_valid) chk("word", 32'(next_input), 32'(wq[0].w));
        void'(wq.pop_front());
      end
      if (efd) void'(fdq.pop_front());
    end
  end
  task automatic drive(input logic [N-1:0] v, input logic [N*DW-1:0] d);
    @(negedge clk);
    vin = v;
    din = d;
  endtask
  task automatic idle(input int n);
    repeat (n) drive('0, '0);
  endtask
  function automatic logic [N*DW-1:0] seq(input logic [DW-1:0] base);
    logic [N*DW-1:0] d;
    for (int i = 0; i < N; i++) d[i*DW +: DW] = base + DW'(i);
    return d;
  endfunction
  function automatic logic [N*DW-1:0] rnd();
    logic [N*DW-1:0] d;
    for (int i = 0; i < N; i++) d[i*DW +: DW] = DW'($urandom);
    return d;
  endfunction
  function automatic logic [N-1:0] one(input int j);
    logic [N-1:0] m = '0;
    m[j] = 1'b1;
    return m;
  endfunction
  initial begin
    logic [N*DW-1:0] d;
    int t;
    rst_n = 1'b0;
    vin = '0;
    din = '0;
    repeat (3) @(negedge clk);
    chk("reset_outs", {27'b0, next_input_valid, busy, frame_done, overrun, |next_input}, 32'h0);
    #2 rst_n = 1'b1;
    mon_en = 1'b1;
    idle(3);
    drive('1, seq(16'h0100));
    idle(15);
    for (int j = N - 1; j >= 0; j--) begin
      drive(one(j), rnd());
      if (j > 0) idle(2);
    end
    idle(15);
    drive('1, seq(16'h0100));
    idle(2);
    drive('1, seq(16'h0200));
    idle(30);
    drive(one(4), {N{16'h1111}});
    idle(1);
    drive(one(4), {N{16'h2222}});
    drive(~one(4), rnd());
    idle(15);
    chk("overrun_sticky", 32'(overrun), 32'h1);
    d = rnd();
    d[0 +: DW] = 16'h8001;
    d[DW +: DW] = 16'hFFFF;
    d[9*DW +: DW] = 16'h8000;
    drive('1, d);
    idle(15);
    repeat (150) drive($urandom & $urandom, rnd());
    idle(40);
    drive('1, seq(16'h0A00));
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!next_input_valid && t < 20);
    chk("stream_start", 32'(next_input_valid), 32'h1);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("async_reset_outs", {27'b0, next_input_valid, busy, frame_done, overrun, |next_input}, 32'h0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    idle(20);
    drive('1, seq(16'h0300));
    idle(5);
    drive(one(2), rnd());
    drive('1 ^ one(2), rnd());
    idle(20);
    t = 0;
    while (wq.size() > 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("drain", 32'(wq.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
